alu_entry_controller: RTL and testbench
=======================================

Name: alu_entry_controller

Overview:
- Sequences operand and opcode entry for the ALU from synchronized push-button pulses and switch inputs.
- Launches the ALU, captures its result, and holds the result for display.
- Sits between the per-button synchronizers (one-cycle edge pulses) and the ALU datapath/display logic.

Parameters:
- WIDTH, 8, operand/result width in bits.
- OPW, 3, opcode width in bits.
- LOCKOUT, 16, cycles after an accepted enter during which further enter pulses are dropped; 0 disables lockout.
- TIMEOUT, 32, maximum cycles spent in RUN waiting for aluDone.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enterPulse  in  1  one-cycle synchronized enter-button edge.
- clearPulse  in  1  one-cycle synchronized clear-button edge.
- switches  in  WIDTH  operand/opcode source; opcode is taken from switches[OPW-1:0].
- aluResult  in  WIDTH  ALU output.
- aluDone  in  1  ALU result valid.
- opA  out  WIDTH  registered operand A.
- opB  out  WIDTH  registered operand B.
- opCode  out  OPW  registered opcode.
- aluStart  out  1  one-cycle ALU launch pulse.
- resultReg  out  WIDTH  captured result.
- resultValid  out  1  resultReg holds a valid result.
- timeoutErr  out  1  last RUN ended by timeout.
- state  out  3  current state encoding, for display.
- busy  out  1  high in RUN.

Behaviour:
- Reset: all outputs 0; state = GET_A (0); lockout counter 0.
- States and encoding: GET_A=0, GET_B=1, GET_OP=2, RUN=3, SHOW=4. Other encodings return to GET_A on the next clock.
- Accepted enter: enterPulse high and lockout counter 0.
  - Every accepted enter loads the counter with LOCKOUT.
  - The counter decrements to 0 each cycle.
  - Enters arriving during lockout are dropped, never queued.
- GET_A: accepted enter -> opA <= switches; go to GET_B.
- GET_B: accepted enter -> opB <= switches; go to GET_OP.
- GET_OP: accepted enter -> opCode <= switches[OPW-1:0]; go to RUN. aluStart is high for exactly the first RUN cycle.
- RUN:
  - aluDone is sampled from the first RUN cycle onward, so same-cycle completion is legal.
  - aluDone -> resultReg <= aluResult; resultValid <= 1; timeoutErr <= 0; go to SHOW.
  - TIMEOUT cycles elapse without aluDone -> resultValid <= 0; timeoutErr <= 1; go to SHOW.
  - Enter pulses are ignored and do not load lockout.
- SHOW: accepted enter -> resultValid <= 0; go to GET_A.
- aluDone outside RUN is ignored.
- clearPulse, from any state:
  - Next state GET_A; opA, opB, opCode, resultValid and timeoutErr cleared; lockout counter cleared.
  - Clear in RUN aborts; aluDone in that same cycle is discarded.
  - Clear takes priority over a simultaneous enter.
  - Clear is not subject to lockout.
- Register and flag behaviour:
  - Registers not named in a transition hold their value.
  - opA, opB and opCode are stable for the whole of RUN.
  - busy = (state == RUN), combinational from state.
- Reset asserted mid-operation: immediate return to reset values, regardless of clock.

Optional Feature:
- Macro: ALU_CHAIN_EN.
- Defined: in SHOW, an accepted enter with resultValid = 1 does opA <= resultReg and goes to GET_B (accumulator chaining). After a timeout, enter goes to GET_A.
- Undefined: SHOW always goes to GET_A on an accepted enter.

Decomposition:
- Package alu_ctrl_pkg:
  - typedef enum logic [2:0] ctrl_state_t with the encodings above.
  - localparam default WIDTH and OPW.
  - opcode typedef logic [OPW-1:0].
- Sub-module press_lockout (parameter LOCKOUT):
  - Inputs: clock, rst, pulse, flush.
  - Output: accept = pulse && counter == 0.
  - Owns the counter; flush is driven by clearPulse.

Test Plan:
- Full sequence: switches 0x12/0x34/3, three enters spaced 20 cycles apart; aluDone with result 0x46 one cycle after aluStart -> opA=0x12, opB=0x34, opCode=3, single aluStart pulse, resultReg=0x46, resultValid=1, state=4.
- Lockout: two enters 5 cycles apart in GET_A with LOCKOUT=16 -> only the first is accepted, state=1; a third enter at cycle 17 is accepted, state=2.
- Timeout: reach RUN and never assert aluDone -> after 32 cycles timeoutErr=1, resultValid=0, state=4; a stray aluDone afterward changes nothing.
- Clear priority: clear and enter in the same cycle in GET_OP -> state=0, opA/opB/opCode=0, no aluStart; clear in RUN coincident with aluDone -> resultValid stays 0.
- Reset mid-RUN: drop rst asynchronously between clock edges -> all outputs 0 immediately, state=0; operation is normal after release.
- With ALU_CHAIN_EN: result 0x46 followed by enter in SHOW -> opA=0x46, state=1. Without the macro: state=0, opA unchanged.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and defaults for the ALU entry controller.
package alu_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 3;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        RUN    = 3'd3,
        SHOW   = 3'd4
    } ctrl_state_t;

    typedef logic [DEF_OPW-1:0] opcode_t;

endpackage

// File: rtl/alu_entry_controller_press_lockout.sv
// Enter-button lockout: after an accepted press, further presses are dropped
// for LOCKOUT cycles. flush (clear button) empties the lockout immediately.
module press_lockout #(
    parameter int LOCKOUT = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic pulse,
    input  logic flush,
    output logic accept
);

    generate
        if (LOCKOUT == 0) begin : g_no_lockout
            logic w_unused_lockout;
            assign w_unused_lockout = clock ^ rst ^ flush;
            assign accept = pulse;
        end else begin : g_lockout
            localparam int CW = $clog2(LOCKOUT + 1);
            logic [CW-1:0] r_count;

            assign accept = pulse && (r_count == '0);

            // Down-counter: load on accept, run to zero, flush on clear.
            always_ff @(posedge clock or negedge rst) begin
                if (!rst) begin
                    r_count <= '0;
                end else if (flush) begin
                    r_count <= '0;
                end else if (accept) begin
                    r_count <= CW'(LOCKOUT);
                end else if (r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/alu_entry_controller.sv
// ALU operand/opcode entry sequencer.
//
// state  | meaning
// GET_A  | waiting for enter to latch operand A from switches
// GET_B  | waiting for enter to latch operand B
// GET_OP | waiting for enter to latch opcode, then launch ALU
// RUN    | ALU launched, waiting for aluDone or timeout
// SHOW   | result (or timeout flag) held for display
//
// Optional build macro ALU_CHAIN_EN: an enter in SHOW with a valid result
// feeds the result back into operand A and skips straight to GET_B.
module alu_entry_controller
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OPW     = DEF_OPW,
    parameter int LOCKOUT = 16,
    parameter int TIMEOUT = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enterPulse,
    input  logic             clearPulse,
    input  logic [WIDTH-1:0] switches,
    input  logic [WIDTH-1:0] aluResult,
    input  logic             aluDone,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic [OPW-1:0]   opCode,
    output logic             aluStart,
    output logic [WIDTH-1:0] resultReg,
    output logic             resultValid,
    output logic             timeoutErr,
    output logic [2:0]       state,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    ctrl_state_t r_state, w_state_nxt;
    logic [TW-1:0] r_timer;
    logic w_enter_req, w_accept;
    logic w_load_a, w_load_b, w_load_op, w_start, w_capture, w_timeout;
    logic w_show_exit, w_chain;
    logic w_unused_sw;

    assign w_unused_sw = ^switches;

    // Enter presses during RUN are ignored entirely, so they never reach the lockout.
    assign w_enter_req = enterPulse && (r_state != RUN);

    press_lockout #(.LOCKOUT(LOCKOUT)) u_lockout (
        .clock (clock),
        .rst   (rst),
        .pulse (w_enter_req),
        .flush (clearPulse),
        .accept(w_accept)
    );

    assign state = r_state;
    assign busy  = (r_state == RUN);

    // State register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) r_state <= GET_A;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode and per-transition load strobes; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_load_op   = 1'b0;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_show_exit = 1'b0;
        w_chain     = 1'b0;
        if (clearPulse) begin
            w_state_nxt = GET_A;
        end else begin
            case (r_state)
                GET_A: if (w_accept) begin
                    w_load_a    = 1'b1;
                    w_state_nxt = GET_B;
                end
                GET_B: if (w_accept) begin
                    w_load_b    = 1'b1;
                    w_state_nxt = GET_OP;
                end
                GET_OP: if (w_accept) begin
                    w_load_op   = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = RUN;
                end
                RUN: begin
                    if (aluDone) begin
                        w_capture   = 1'b1;
                        w_state_nxt = SHOW;
                    end else if (r_timer == '0) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = SHOW;
                    end
                end
                SHOW: if (w_accept) begin
                    w_show_exit = 1'b1;
`ifdef ALU_CHAIN_EN
                    if (resultValid) begin
                        w_chain     = 1'b1;
                        w_state_nxt = GET_B;
                    end else begin
                        w_state_nxt = GET_A;
                    end
`else
                    w_state_nxt = GET_A;
`endif
                end
                default: w_state_nxt = GET_A;
            endcase
        end
    end

    // Operand, opcode, result and flag registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            opA         <= '0;
            opB         <= '0;
            opCode      <= '0;
            aluStart    <= 1'b0;
            resultReg   <= '0;
            resultValid <= 1'b0;
            timeoutErr  <= 1'b0;
        end else begin
            aluStart <= w_start;
            if (clearPulse) begin
                opA         <= '0;
                opB         <= '0;
                opCode      <= '0;
                resultValid <= 1'b0;
                timeoutErr  <= 1'b0;
            end else begin
                if (w_load_a)  opA    <= switches;
                if (w_chain)   opA    <= resultReg;
                if (w_load_b)  opB    <= switches;
                if (w_load_op) opCode <= switches[OPW-1:0];
                if (w_capture) begin
                    resultReg   <= aluResult;
                    resultValid <= 1'b1;
                    timeoutErr  <= 1'b0;
                end
                if (w_timeout) begin
                    resultValid <= 1'b0;
                    timeoutErr  <= 1'b1;
                end
                if (w_show_exit) resultValid <= 1'b0;
            end
        end
    end

    // RUN timeout down-counter: loaded on launch so it reads zero in the last allowed RUN cycle.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (w_start) begin
            r_timer <= TW'(TIMEOUT - 1);
        end else if (r_state == RUN && r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_entry_controller.sv
// Directed, table-driven bench for alu_entry_controller (LOCKOUT=16, TIMEOUT=32).
module tb_alu_entry_controller;

`ifdef ALU_CHAIN_EN
    localparam bit CH = 1'b1;
`else
    localparam bit CH = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       enterPulse = 1'b0, clearPulse = 1'b0, aluDone = 1'b0;
    logic [7:0] switches = '0, aluResult = '0;
    logic [7:0] opA, opB, resultReg;
    logic [2:0] opCode, state;
    logic       aluStart, resultValid, timeoutErr, busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_entry_controller #(.WIDTH(8), .OPW(3), .LOCKOUT(16), .TIMEOUT(32)) dut (
        .clock(clock), .rst(rst), .enterPulse(enterPulse), .clearPulse(clearPulse),
        .switches(switches), .aluResult(aluResult), .aluDone(aluDone),
        .opA(opA), .opB(opB), .opCode(opCode), .aluStart(aluStart),
        .resultReg(resultReg), .resultValid(resultValid), .timeoutErr(timeoutErr),
        .state(state), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         gap;
        logic       en, clr;
        logic [7:0] sw;
        logic       dn;
        logic [7:0] res;
        logic [2:0] st;
        logic [7:0] a, b;
        logic [2:0] op;
        logic       start;
        logic [7:0] rr;
        logic       rv, te;
    } vec_t;

    vec_t vecs[29];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [2:0] st, logic [7:0] a, logic [7:0] b,
                           logic [2:0] op, logic start, logic [7:0] rr, logic rv, logic te);
        chk({tag, ".state"},       32'(state),       32'(st));
        chk({tag, ".opA"},         32'(opA),         32'(a));
        chk({tag, ".opB"},         32'(opB),         32'(b));
        chk({tag, ".opCode"},      32'(opCode),      32'(op));
        chk({tag, ".aluStart"},    32'(aluStart),    32'(start));
        chk({tag, ".resultReg"},   32'(resultReg),   32'(rr));
        chk({tag, ".resultValid"}, 32'(resultValid), 32'(rv));
        chk({tag, ".timeoutErr"},  32'(timeoutErr),  32'(te));
        chk({tag, ".busy"},        32'(busy),        32'(st == 3'd3));
    endtask

    task automatic apply(int i);
        vec_t v;
        v = vecs[i];
        enterPulse = 1'b0; clearPulse = 1'b0; aluDone = 1'b0; aluResult = '0;
        switches = v.sw;
        repeat (v.gap) tick();
        enterPulse = v.en; clearPulse = v.clr; aluDone = v.dn; aluResult = v.res;
        tick();
        enterPulse = 1'b0; clearPulse = 1'b0; aluDone = 1'b0; aluResult = '0;
        chk_all($sformatf("v%0d", i), v.st, v.a, v.b, v.op, v.start, v.rr, v.rv, v.te);
    endtask

    initial begin
        //          gap en clr sw     dn res   | st      a                  b      op    start rr     rv    te
        vecs[0]  = '{2,  1, 0, 8'h12, 0, 8'h00, 3'd1, 8'h12,             8'h00, 3'd0, 0, 8'h00, 0, 0};
        vecs[1]  = '{4,  1, 0, 8'h34, 0, 8'h00, 3'd1, 8'h12,             8'h00, 3'd0, 0, 8'h00, 0, 0};
        vecs[2]  = '{11, 1, 0, 8'h34, 0, 8'h00, 3'd2, 8'h12,             8'h34, 3'd0, 0, 8'h00, 0, 0};
        vecs[3]  = '{19, 1, 0, 8'h03, 0, 8'h00, 3'd3, 8'h12,             8'h34, 3'd3, 1, 8'h00, 0, 0};
        vecs[4]  = '{0,  0, 0, 8'h00, 1, 8'h46, 3'd4, 8'h12,             8'h34, 3'd3, 0, 8'h46, 1, 0};
        vecs[5]  = '{19, 1, 0, 8'hFF, 0, 8'h00, CH ? 3'd1 : 3'd0, CH ? 8'h46 : 8'h12,
                                                                         8'h34, 3'd3, 0, 8'h46, 0, 0};
        vecs[6]  = '{1,  0, 1, 8'h00, 0, 8'h00, 3'd0, 8'h00,             8'h00, 3'd0, 0, 8'h46, 0, 0};
        vecs[7]  = '{0,  1, 0, 8'h05, 0, 8'h00, 3'd1, 8'h05,             8'h00, 3'd0, 0, 8'h46, 0, 0};
        vecs[8]  = '{19, 1, 0, 8'h07, 0, 8'h00, 3'd2, 8'h05,             8'h07, 3'd0, 0, 8'h46, 0, 0};
        vecs[9]  = '{19, 1, 1, 8'h02, 0, 8'h00, 3'd0, 8'h00,             8'h00, 3'd0, 0, 8'h46, 0, 0};
        vecs[10] = '{0,  1, 0, 8'h0A, 0, 8'h00, 3'd1, 8'h0A,             8'h00, 3'd0, 0, 8'h46, 0, 0};
        vecs[11] = '{19, 1, 0, 8'h0B, 0, 8'h00, 3'd2, 8'h0A,             8'h0B, 3'd0, 0, 8'h46, 0, 0};
        vecs[12] = '{19, 1, 0, 8'h01, 0, 8'h00, 3'd3, 8'h0A,             8'h0B, 3'd1, 1, 8'h46, 0, 0};
        vecs[13] = '{30, 1, 0, 8'hEE, 0, 8'h00, 3'd3, 8'h0A,             8'h0B, 3'd1, 0, 8'h46, 0, 0};
        vecs[14] = '{0,  0, 0, 8'h00, 0, 8'h00, 3'd4, 8'h0A,             8'h0B, 3'd1, 0, 8'h46, 0, 1};
        vecs[15] = '{2,  0, 0, 8'h00, 1, 8'h99, 3'd4, 8'h0A,             8'h0B, 3'd1, 0, 8'h46, 0, 1};
        vecs[16] = '{0,  1, 0, 8'h00, 0, 8'h00, 3'd0, 8'h0A,             8'h0B, 3'd1, 0, 8'h46, 0, 1};
        vecs[17] = '{19, 1, 0, 8'h01, 0, 8'h00, 3'd1, 8'h01,             8'h0B, 3'd1, 0, 8'h46, 0, 1};
        vecs[18] = '{19, 1, 0, 8'h02, 0, 8'h00, 3'd2, 8'h01,             8'h02, 3'd1, 0, 8'h46, 0, 1};
        vecs[19] = '{19, 1, 0, 8'h03, 0, 8'h00, 3'd3, 8'h01,             8'h02, 3'd3, 1, 8'h46, 0, 1};
        vecs[20] = '{0,  0, 1, 8'h00, 1, 8'h55, 3'd0, 8'h00,             8'h00, 3'd0, 0, 8'h46, 0, 0};
        vecs[21] = '{0,  1, 0, 8'h21, 0, 8'h00, 3'd1, 8'h21,             8'h00, 3'd0, 0, 8'h46, 0, 0};
        vecs[22] = '{19, 1, 0, 8'h22, 0, 8'h00, 3'd2, 8'h21,             8'h22, 3'd0, 0, 8'h46, 0, 0};
        vecs[23] = '{19, 1, 0, 8'h04, 0, 8'h00, 3'd3, 8'h21,             8'h22, 3'd4, 1, 8'h46, 0, 0};
        // after mid-RUN reset
        vecs[24] = '{1,  1, 0, 8'h11, 0, 8'h00, 3'd1, 8'h11,             8'h00, 3'd0, 0, 8'h00, 0, 0};
        vecs[25] = '{19, 1, 0, 8'h22, 0, 8'h00, 3'd2, 8'h11,             8'h22, 3'd0, 0, 8'h00, 0, 0};
        vecs[26] = '{19, 1, 0, 8'h05, 0, 8'h00, 3'd3, 8'h11,             8'h22, 3'd5, 1, 8'h00, 0, 0};
        vecs[27] = '{0,  0, 0, 8'h00, 1, 8'h33, 3'd4, 8'h11,             8'h22, 3'd5, 0, 8'h33, 1, 0};
        vecs[28] = '{19, 1, 0, 8'h00, 0, 8'h00, CH ? 3'd1 : 3'd0, CH ? 8'h33 : 8'h11,
                                                                         8'h22, 3'd5, 0, 8'h33, 0, 0};

        // Reset state while held and just after release.
        repeat (2) tick();
        chk_all("reset_held", 3'd0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 0, 0);
        #2 rst = 1'b1;
        tick();
        chk_all("reset_rel", 3'd0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 0, 0);

        for (int i = 0; i <= 23; i++) apply(i);

        // Asynchronous reset between edges while in RUN.
        #2 rst = 1'b0;
        #1 chk_all("async_rst", 3'd0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 0, 0);
        tick();
        #3 rst = 1'b1;

        for (int i = 24; i <= 28; i++) apply(i);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
